// File: rtl/vga_term_writer_if.sv
// rtl/vga_term_writer_if.sv - character stream, Wishbone master bus and cursor bundle
//
// Purpose: groups every non-clock, non-reset signal of vga_term_writer.
// Signals:
//   ch_i / ch_valid_i / ch_ready_o      : console byte stream into the writer
//   wb_adr_o / wb_dat_o / wb_dat_i      : Wishbone byte address, write data, read data
//   wb_cyc_o / wb_stb_o / wb_we_o       : Wishbone cycle, strobe, write enable
//   wb_sel_o / wb_ack_i                 : byte select ([0] even byte), acknowledge
//   cursor_o / busy_o                   : cursor character address, command in progress
// Modports: master = the writer, slave = byte source plus video memory side.
interface vga_term_writer_if;
  logic [7:0]  ch_i;
  logic        ch_valid_i;
  logic        ch_ready_o;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i;
  logic [12:0] cursor_o;
  logic        busy_o;

  modport master (
    input  ch_i, ch_valid_i, wb_dat_i, wb_ack_i,
    output ch_ready_o, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
           cursor_o, busy_o
  );

  modport slave (
    output ch_i, ch_valid_i, wb_dat_i, wb_ack_i,
    input  ch_ready_o, wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
           cursor_o, busy_o
  );
endinterface

// File: rtl/vga_term_writer.sv
// rtl/vga_term_writer.sv - byte stream to 80x25 text buffer writer with scroll and clear
//
// Purpose: accepts console bytes, handles CR/LF/BS/FF, writes printable codes into
// the text video buffer over Wishbone, scrolls the terminal rows by memory copy and
// keeps the adapter cursor address up to date. Row 0 (service line) is never touched.
// Ports:
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset
//   bus      : vga_term_writer_if.master (byte stream, Wishbone master, cursor, busy)
module vga_term_writer #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 25,
  parameter int          FIRST_ROW = 1,
  parameter logic [15:0] BASE_ADR  = 16'h0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  vga_term_writer_if.master bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  // Word indices: first terminal word, last scroll destination, last row, end of screen
  localparam logic [10:0]   W_FIRST    = 11'(FIRST_ROW * COLS / 2);
  localparam logic [10:0]   W_SCR_LAST = 11'((ROWS - 1) * COLS / 2 - 1);
  localparam logic [10:0]   W_LAST_ROW = 11'((ROWS - 1) * COLS / 2);
  localparam logic [10:0]   W_END      = 11'(ROWS * COLS / 2 - 1);
  localparam logic [10:0]   W_HALF     = 11'(COLS / 2);
  localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX    = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_FIRST  = RW'(FIRST_ROW);
  localparam logic [15:0]   SPACES     = 16'h2020;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WR_CHAR, S_SCR_RD, S_SCR_WR, S_CLR_WR
  } state_t;

  state_t        r_state;
  logic [7:0]    r_ch;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [10:0]   r_word;
  logic [15:0]   r_rd_dat;
  logic [12:0]   r_cursor;
  logic          r_ready;
  logic          r_busy;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic [1:0]    r_sel;
  logic [15:0]   r_adr;
  logic [15:0]   r_dat;

  logic [CW-1:0] w_col_inc;
  logic [CW-1:0] w_col_dec;
  logic [RW-1:0] w_row_inc;
  logic [10:0]   w_src_word;
  logic [15:0]   w_char_adr;
  logic          w_ack;

  function automatic logic [12:0] f_pos(logic [RW-1:0] row, logic [CW-1:0] col);
    return 13'(row) * 13'(COLS) + 13'(col);
  endfunction

  function automatic logic [15:0] f_word_adr(logic [10:0] w);
    return BASE_ADR + {4'b0000, w, 1'b0};
  endfunction

  assign w_col_inc  = r_col + 1'b1;
  assign w_col_dec  = r_col - 1'b1;
  assign w_row_inc  = r_row + 1'b1;
  assign w_src_word = r_word + W_HALF;
  // cursor_o still holds the character address while the write is in flight
  assign w_char_adr = BASE_ADR + {3'b000, r_cursor[12:1], 1'b0};
  // A bus state issues its cycle when cyc is low and completes on ack; the idle
  // cycle after each ack gives the mandatory gap between transactions.
  assign w_ack      = r_cyc & bus.wb_ack_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_ch     <= 8'h00;
      r_col    <= '0;
      r_row    <= ROW_FIRST;
      r_word   <= 11'd0;
      r_rd_dat <= 16'h0000;
      r_cursor <= 13'(FIRST_ROW * COLS);
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= 2'b00;
      r_adr    <= 16'h0000;
      r_dat    <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ch_valid_i) begin
            r_ch    <= bus.ch_i;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (r_ch)
            8'h0D: begin
              r_col    <= '0;
              r_cursor <= f_pos(r_row, {CW{1'b0}});
              r_state  <= S_IDLE;
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end
            8'h0A: begin
              if (r_row != ROW_MAX) begin
                r_row    <= w_row_inc;
                r_cursor <= f_pos(w_row_inc, r_col);
                r_state  <= S_IDLE;
                r_ready  <= 1'b1;
                r_busy   <= 1'b0;
              end else begin
                r_word  <= W_FIRST;
                r_state <= S_SCR_RD;
              end
            end
            8'h08: begin
              if (r_col != '0) begin
                r_col    <= w_col_dec;
                r_cursor <= f_pos(r_row, w_col_dec);
              end
              r_state <= S_IDLE;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
            8'h0C: begin
              // Final position is set now; cursor_o follows when the clear ends
              r_col   <= '0;
              r_row   <= ROW_FIRST;
              r_word  <= W_FIRST;
              r_state <= S_CLR_WR;
            end
            default: r_state <= S_WR_CHAR;
          endcase
        end

        S_WR_CHAR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= w_char_adr;
            r_dat <= {r_ch, r_ch};
            r_sel <= r_cursor[0] ? 2'b10 : 2'b01;
          end else if (w_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_col != COL_MAX) begin
              r_col    <= w_col_inc;
              r_cursor <= f_pos(r_row, w_col_inc);
              r_state  <= S_IDLE;
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end else if (r_row != ROW_MAX) begin
              r_col    <= '0;
              r_row    <= w_row_inc;
              r_cursor <= f_pos(w_row_inc, {CW{1'b0}});
              r_state  <= S_IDLE;
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_col   <= '0;
              r_word  <= W_FIRST;
              r_state <= S_SCR_RD;
            end
          end
        end

        S_SCR_RD: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_adr <= f_word_adr(w_src_word);
            r_sel <= 2'b11;
          end else if (w_ack) begin
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_rd_dat <= bus.wb_dat_i;
            r_state  <= S_SCR_WR;
          end
        end

        S_SCR_WR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= f_word_adr(r_word);
            r_dat <= r_rd_dat;
            r_sel <= 2'b11;
          end else if (w_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_word == W_SCR_LAST) begin
              r_word  <= W_LAST_ROW;
              r_state <= S_CLR_WR;
            end else begin
              r_word  <= r_word + 11'd1;
              r_state <= S_SCR_RD;
            end
          end
        end

        S_CLR_WR: begin
          if (!r_cyc) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= f_word_adr(r_word);
            r_dat <= SPACES;
            r_sel <= 2'b11;
          end else if (w_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_word == W_END) begin
              r_cursor <= f_pos(r_row, r_col);
              r_state  <= S_IDLE;
              r_ready  <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_word <= r_word + 11'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ch_ready_o = r_ready;
  assign bus.busy_o     = r_busy;
  assign bus.cursor_o   = r_cursor;
  assign bus.wb_cyc_o   = r_cyc;
  assign bus.wb_stb_o   = r_stb;
  assign bus.wb_we_o    = r_we;
  assign bus.wb_sel_o   = r_sel;
  assign bus.wb_adr_o   = r_adr;
  assign bus.wb_dat_o   = r_dat;
endmodule

// File: doc/vga_term_writer.md
Name: vga_term_writer

Overview:
- Wishbone master that turns a byte stream (console output) into character writes into the text video buffer of the 80x25 VGA text adapter.
- Interprets control codes CR, LF, BS and FF; scrolls the terminal area by copying video memory.
- Drives the adapter's cursor address input.
- Row 0 is the service line: the writer never modifies it. The terminal area is rows FIRST_ROW..ROWS-1.

Parameters:
COLS, 80, characters per row (even)
ROWS, 25, rows per screen
FIRST_ROW, 1, first row owned by the terminal
BASE_ADR, 16'h0000, byte address of character 0 in the video buffer window

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
ch_i  in  8  input character
ch_valid_i  in  1  ch_i is valid
ch_ready_o  out  1  writer can accept a character
wb_adr_o  out  16  byte address; bit 0 is always 0
wb_dat_o  out  16  write data
wb_dat_i  in  16  read data
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  bus strobe
wb_we_o  out  1  1 = write
wb_sel_o  out  2  byte select, [0] = even byte, [1] = odd byte
wb_ack_i  in  1  acknowledge
cursor_o  out  13  cursor character address = row*COLS+col
busy_o  out  1  transaction or scroll/clear in progress

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high. All outputs are registered.
- Reset values, applied in any state (including mid-scroll) on the next edge:
  - cyc/stb/we = 0; sel = 0; adr/dat = 0
  - ch_ready_o = 1; busy_o = 0
  - cursor_o = FIRST_ROW*COLS (80); internal col = 0, row = FIRST_ROW
- Input handshake: a byte is accepted on an edge where ch_valid_i & ch_ready_o. ch_ready_o = 1 only in IDLE; it drops on the accept edge. busy_o = ~ch_ready_o.
- Bus rules:
  - cyc_o and stb_o assert together; adr/dat/we/sel are held constant until wb_ack_i is sampled high.
  - cyc/stb deassert on the ack edge and stay low for at least 1 cycle between transactions.
  - No timeout.
- Character write: address = BASE_ADR + (char address with bit 0 cleared); sel = 2'b01 if char address is even, else 2'b10; dat = {ch,ch}.
- States: IDLE, DECODE, WR_CHAR, SCR_RD, SCR_WR, CLR_WR. DECODE takes one cycle after accept. Actions by character:
  - 0x0D (CR): col = 0; back to IDLE.
  - 0x0A (LF): if row < ROWS-1, row+1, col unchanged; otherwise run SCROLL, row stays ROWS-1.
  - 0x08 (BS): col-1 if col > 0, else no change; no bus access.
  - 0x0C (FF): CLR_WR over (ROWS-FIRST_ROW)*COLS/2 = 960 words, dat 16'h2020, sel 11, starting at word FIRST_ROW*COLS/2 and ascending. Then col = 0, row = FIRST_ROW.
  - Any other code (0x00-0xFF): WR_CHAR at the cursor, then col+1. If col was COLS-1: col = 0, then row+1, or SCROLL if row = ROWS-1.
- SCROLL: 920 (= (ROWS-1-FIRST_ROW)*COLS/2) pairs, each a read then a write.
  - SCR_RD reads word k+COLS/2 with sel 11 and latches wb_dat_i on ack.
  - SCR_WR writes that data to word k with sel 11.
  - k runs from FIRST_ROW*COLS/2 ascending.
  - Then CLR_WR clears the last row: 40 words of 16'h2020.
- Counters: word index 11 bits; cursor 13 bits. No wrap beyond ROWS*COLS-1 is ever possible.
- cursor_o updates on the edge leaving the final state of each command. It is constant during scroll/clear.

Test Plan:
- Reset with ch_valid_i=1 -> cursor_o=80, cyc=0, ready=1; nothing accepted until reset drops; then 'A' is written.
- 'A'(0x41) at home -> one write: adr=BASE+80, sel=01, dat=0x4141, we=1; cursor_o=81. Then 'B' -> adr=BASE+80, sel=10, dat=0x4242; cursor_o=82.
- Cursor 159 (row 1, col 79) plus 'x' -> write sel=10 at adr=BASE+158; cursor_o=160. CR -> 160; BS at col 0 -> 160, no bus cycle; BS at 165 -> 164.
- Cursor 1925 plus LF -> 920 read/write pairs: first read adr=BASE+160, first write adr=BASE+80 with the data read. Then 40 writes of 0x2020 from BASE+1920 to BASE+1998. Cursor_o stays 1925; service row (adr < BASE+80) is never written.
- FF from any cursor -> 960 writes of 0x2020, adr BASE+80..BASE+1998; cursor_o=80; ack delayed 3 cycles on each -> adr/dat stable until ack.
- Reset asserted mid-scroll (at pair 300) -> next edge cyc=stb=0, cursor_o=80, ready=1; a subsequent 'A' is written normally.
